// File: rtl/sim_display_pkg.sv
// Segment encodings and bit order shared by the multiplexed 7-segment display driver.
package sim_display_pkg;

    localparam int unsigned SEG_WIDTH = 7;

    typedef logic [SEG_WIDTH-1:0] seg_t;

    // Segment bit positions on the sevenSegOut bus (no decimal point).
    typedef enum int unsigned {
        SEG_BIT_A = 0,
        SEG_BIT_B = 1,
        SEG_BIT_C = 2,
        SEG_BIT_D = 3,
        SEG_BIT_E = 4,
        SEG_BIT_F = 5,
        SEG_BIT_G = 6
    } seg_bit_e;

    localparam seg_t SEG_0    = 7'h3F;
    localparam seg_t SEG_1    = 7'h06;
    localparam seg_t SEG_2    = 7'h5B;
    localparam seg_t SEG_3    = 7'h4F;
    localparam seg_t SEG_4    = 7'h66;
    localparam seg_t SEG_5    = 7'h6D;
    localparam seg_t SEG_6    = 7'h7D;
    localparam seg_t SEG_7    = 7'h07;
    localparam seg_t SEG_8    = 7'h7F;
    localparam seg_t SEG_9    = 7'h6F;
    localparam seg_t SEG_DASH = 7'h40;
    localparam seg_t SEG_OFF  = 7'h00;

endpackage

// File: rtl/sim_display_mux_if.sv
// Count-capture input and segment/digit pin bundle of the display driver.
interface sim_display_mux_if #(
    parameter int unsigned DIGITS = 4
);
    import sim_display_pkg::*;

    logic [4*DIGITS-1:0] validCount;
    logic                validStrobe;
    seg_t                sevenSegOut;
    logic [DIGITS-1:0]   digitEn;
    logic                frameTick;

    modport master (
        output validCount,
        output validStrobe,
        input  sevenSegOut,
        input  digitEn,
        input  frameTick
    );

    modport slave (
        input  validCount,
        input  validStrobe,
        output sevenSegOut,
        output digitEn,
        output frameTick
    );

endinterface

// File: rtl/bcd_to_7seg.sv
// Combinational BCD-to-segment decoder; non-BCD nibbles render as a dash.
module bcd_to_7seg
    import sim_display_pkg::*;
(
    input  logic [3:0] bcd,
    output seg_t       seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (bcd)
            4'd0:    seg_c = SEG_0;
            4'd1:    seg_c = SEG_1;
            4'd2:    seg_c = SEG_2;
            4'd3:    seg_c = SEG_3;
            4'd4:    seg_c = SEG_4;
            4'd5:    seg_c = SEG_5;
            4'd6:    seg_c = SEG_6;
            4'd7:    seg_c = SEG_7;
            4'd8:    seg_c = SEG_8;
            4'd9:    seg_c = SEG_9;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/sim_display_mux.sv
// Time-multiplexed multi-digit 7-segment driver with tear-free frame-boundary update.
// Optional leading-zero suppression: define SIM_DISPLAY_LEADING_ZERO_BLANK_EN.
module sim_display_mux #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned REFRESH_DIV  = 1000,
    parameter int unsigned BLANK_CYCLES = 12,
    parameter int unsigned SEG_WIDTH    = 7
) (
    input  logic              clk,
    input  logic              rstN,
    sim_display_mux_if.slave  bus
);
    import sim_display_pkg::*;

    localparam int unsigned SLOT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BLANK_START = REFRESH_DIV - BLANK_CYCLES;

    logic [SLOT_W-1:0]     slotCnt;
    logic [IDX_W-1:0]      digitIdx;
    logic [DIGITS-1:0][3:0] shadow;
    logic [DIGITS-1:0][3:0] shown;

    logic [SEG_WIDTH-1:0]  segQ;
    logic [DIGITS-1:0]     digitEnQ;
    logic                  frameTickQ;

    logic                  slotWrap_c;
    logic                  idxWrap_c;
    logic                  blank_c;
    logic                  suppress_c;
    logic [3:0]            curNibble_c;
    seg_t                  segDec_c;

    assign slotWrap_c  = (slotCnt == SLOT_W'(REFRESH_DIV - 1));
    assign idxWrap_c   = (digitIdx == IDX_W'(DIGITS - 1));
    assign blank_c     = (32'(slotCnt) >= BLANK_START);
    assign curNibble_c = shown[digitIdx];

    bcd_to_7seg u_dec (
        .bcd   (curNibble_c),
        .seg_c (segDec_c)
    );

`ifdef SIM_DISPLAY_LEADING_ZERO_BLANK_EN
    logic [4*DIGITS-1:0] shownFlat_c;
    logic [DIGITS-1:0]   zeroFrom_c;

    // zeroFrom_c[i]: every nibble from i up to the MSD is zero.
    always_comb begin
        shownFlat_c = shown;
        zeroFrom_c  = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            zeroFrom_c[i] = ((shownFlat_c >> (4 * i)) == '0);
        end
    end

    assign suppress_c = (digitIdx != '0) && zeroFrom_c[digitIdx];
`else
    assign suppress_c = 1'b0;
`endif

    // Slot/digit scan counters plus capture and frame-boundary transfer.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            slotCnt  <= '0;
            digitIdx <= '0;
            shadow   <= '0;
            shown    <= '0;
        end else begin
            if (slotWrap_c) begin
                slotCnt  <= '0;
                digitIdx <= idxWrap_c ? '0 : digitIdx + IDX_W'(1);
            end else begin
                slotCnt <= slotCnt + SLOT_W'(1);
            end
            if (bus.validStrobe) begin
                shadow <= bus.validCount;
            end
            if (slotWrap_c && idxWrap_c) begin
                shown <= shadow;
            end
        end
    end

    // Pin registers: one cycle behind the counter state they describe.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            segQ       <= '0;
            digitEnQ   <= '0;
            frameTickQ <= 1'b0;
        end else begin
            frameTickQ <= (slotCnt == '0) && (digitIdx == '0);
            if (blank_c) begin
                segQ     <= '0;
                digitEnQ <= '0;
            end else begin
                digitEnQ <= DIGITS'(1) << digitIdx;
                segQ     <= suppress_c ? SEG_WIDTH'(SEG_OFF) : SEG_WIDTH'(segDec_c);
            end
        end
    end

    assign bus.sevenSegOut = segQ;
    assign bus.digitEn     = digitEnQ;
    assign bus.frameTick   = frameTickQ;

endmodule

// File: tb/tb_sim_display_mux.sv
// Directed bench for sim_display_mux at DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_sim_display_mux;

    logic clk = 1'b0;
    logic rstN;
    int   checks = 0;
    int   errors = 0;

    sim_display_mux_if #(.DIGITS(4)) bus ();

    sim_display_mux #(
        .DIGITS       (4),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2),
        .SEG_WIDTH    (7)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    always #5 clk = ~clk;

`ifdef SIM_DISPLAY_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h00;
`else
    localparam logic [6:0] LZ = 7'h3F;
`endif

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Walks output cycles 1..lastCycle of one frame; optionally strobes val into the edge after cycle strobeAt.
    task automatic runFrame(input string name, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input int lastCycle,
                            input int strobeAt, input logic [15:0] val);
        logic [6:0] segs [4];
        int         slot;
        int         dig;
        logic [3:0] expEn;
        logic [6:0] expSeg;
        segs = '{s0, s1, s2, s3};
        for (int c = 1; c <= lastCycle; c++) begin
            @(negedge clk);
            slot   = (c - 1) % 8;
            dig    = (c - 1) / 8;
            expEn  = (slot < 6) ? 4'(1 << dig) : 4'h0;
            expSeg = (slot < 6) ? segs[dig] : 7'h00;
            check($sformatf("%s c%0d tick", name, c), 16'(bus.frameTick), 16'(c == 1));
            check($sformatf("%s c%0d en", name, c), 16'(bus.digitEn), 16'(expEn));
            check($sformatf("%s c%0d seg", name, c), 16'(bus.sevenSegOut), 16'(expSeg));
            bus.validStrobe = (c == strobeAt);
            if (c == strobeAt) bus.validCount = val;
        end
    endtask

    initial begin
        rstN            = 1'b0;
        bus.validCount  = 16'h0000;
        bus.validStrobe = 1'b0;
        repeat (2) @(negedge clk);
        check("rst tick", 16'(bus.frameTick), 16'h0);
        check("rst en", 16'(bus.digitEn), 16'h0);
        check("rst seg", 16'(bus.sevenSegOut), 16'h0);
        rstN = 1'b1;

        // Zeros after reset; 1234 strobed mid-frame must not tear.
        runFrame("f1_zero", 7'h3F, LZ, LZ, LZ, 32, 10, 16'h1234);
        runFrame("f2_1234", 7'h66, 7'h4F, 7'h5B, 7'h06, 32, 0, 16'h0);
        // Strobe lands on the frame-boundary edge.
        runFrame("f3_1234", 7'h66, 7'h4F, 7'h5B, 7'h06, 32, 31, 16'h5678);
        runFrame("f4_old", 7'h66, 7'h4F, 7'h5B, 7'h06, 32, 0, 16'h0);
        runFrame("f5_5678", 7'h7F, 7'h07, 7'h7D, 7'h6D, 32, 20, 16'h9B10);
        runFrame("f6_9b10", 7'h3F, 7'h06, 7'h40, 7'h6F, 32, 0, 16'h0);
        // Into the digit-2 slot, then asynchronous reset between edges.
        runFrame("f7_part", 7'h3F, 7'h06, 7'h40, 7'h6F, 18, 0, 16'h0);
        #2 rstN = 1'b0;
        #1;
        check("async rst tick", 16'(bus.frameTick), 16'h0);
        check("async rst en", 16'(bus.digitEn), 16'h0);
        check("async rst seg", 16'(bus.sevenSegOut), 16'h0);
        @(negedge clk);
        check("held rst en", 16'(bus.digitEn), 16'h0);
        @(negedge clk);
        rstN = 1'b1;

        runFrame("f8_restart", 7'h3F, LZ, LZ, LZ, 32, 5, 16'h0050);
        runFrame("f9_0050", 7'h3F, 7'h6D, LZ, LZ, 32, 0, 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
